// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for an N x N systolic array.
// Buffers one A tile and one B tile, then streams A rows into the left edge
// and B columns into the top edge with a one-cycle diagonal skew per lane.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, buffers writable
// CLEAR  | one cycle, pulse acc_clr to the PE accumulators
// FEED   | 2N-1 cycles, step t = 0..2N-2 drives skewed edge lanes
// DRAIN  | N cycles, lets the last products reach PE(N-1,N-1)
// DONE   | one cycle, done pulse; start here re-enters CLEAR
//
// Outputs are decoded from the registered state and registered again, so
// every output trails the state register by one cycle.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [$clog2(N)-1:0]  wr_row,
    input  logic [$clog2(N)-1:0]  wr_col,
    input  logic [DW-1:0]         wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_clr,
    output logic [N*DW-1:0]       a_edge,
    output logic [N*DW-1:0]       b_edge,
    output logic [N-1:0]          a_vld,
    output logic [N-1:0]          b_vld
);

    localparam int AW = $clog2(N);
    localparam int SW = $clog2(2*N-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;

    logic [DW-1:0]   a_mem_q [N][N];
    logic [DW-1:0]   a_mem_d [N][N];
    logic [DW-1:0]   b_mem_q [N][N];
    logic [DW-1:0]   b_mem_d [N][N];

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            acc_clr_q, acc_clr_d;
    logic [N*DW-1:0] a_edge_q, a_edge_d;
    logic [N*DW-1:0] b_edge_q, b_edge_d;
    logic [N-1:0]    a_vld_q, a_vld_d;
    logic [N-1:0]    b_vld_q, b_vld_d;

    // Next-state and step counter; start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                step_d  = '0;
            end
            S_FEED: begin
                if (step_q == SW'(2*N-2)) begin
                    state_d = S_DRAIN;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (step_q == SW'(N-1)) begin
                    state_d = S_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = start ? S_CLEAR : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Buffer write port, locked out while the visible busy flag is high.
    always_comb begin
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        if (wr_en && !busy_q && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
            if (wr_sel) b_mem_d[wr_row][wr_col] = wr_data;
            else        a_mem_d[wr_row][wr_col] = wr_data;
        end
    end

    // Output decode: lane i of A carries A[i][t-i], lane j of B carries B[t-j][j].
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        acc_clr_d = 1'b0;
        a_edge_d  = '0;
        b_edge_d  = '0;
        a_vld_d   = '0;
        b_vld_d   = '0;
        case (state_q)
            S_CLEAR: begin
                busy_d    = 1'b1;
                acc_clr_d = 1'b1;
            end
            S_FEED: begin
                busy_d = 1'b1;
                for (int i = 0; i < N; i++) begin
                    if ((int'(step_q) >= i) && (int'(step_q) < i + N)) begin
                        a_edge_d[i*DW +: DW] = a_mem_q[i][AW'(int'(step_q) - i)];
                        a_vld_d[i]           = 1'b1;
                        b_edge_d[i*DW +: DW] = b_mem_q[AW'(int'(step_q) - i)][i];
                        b_vld_d[i]           = 1'b1;
                    end
                end
            end
            S_DRAIN: busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State, buffers and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem_q[r][c] <= '0;
                    b_mem_q[r][c] <= '0;
                end
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            a_edge_q  <= '0;
            b_edge_q  <= '0;
            a_vld_q   <= '0;
            b_vld_q   <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_mem_q   <= a_mem_d;
            b_mem_q   <= b_mem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_clr_q <= acc_clr_d;
            a_edge_q  <= a_edge_d;
            b_edge_q  <= b_edge_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_clr = acc_clr_q;
    assign a_edge  = a_edge_q;
    assign b_edge  = b_edge_q;
    assign a_vld   = a_vld_q;
    assign b_vld   = b_vld_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a schedule-based reference model checks
// every cycle, plus a table of hand-computed FEED vectors and corner sequences.
module tb_systolic_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en, wr_sel, start;
    logic [1:0]      wr_row, wr_col;
    logic [DW-1:0]   wr_data;
    logic            busy, done, acc_clr;
    logic [N*DW-1:0] a_edge, b_edge;
    logic [N-1:0]    a_vld, b_vld;

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .acc_clr(acc_clr),
        .a_edge(a_edge), .b_edge(b_edge), .a_vld(a_vld), .b_vld(b_vld)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: tile contents plus "edges since start was accepted".
    logic [DW-1:0]   ref_a [N][N];
    logic [DW-1:0]   ref_b [N][N];
    bit              running;
    int              cnt;
    logic            exp_busy, exp_done, exp_clr;
    logic [N*DW-1:0] exp_a, exp_b;
    logic [N-1:0]    exp_av, exp_bv;

    typedef struct {
        int              k;
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        logic [N-1:0]    av;
        logic [N-1:0]    bv;
        logic            bsy;
        logic            dn;
        logic            clr;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ref_a[r][c] = '0;
                ref_b[r][c] = '0;
            end
        running  = 0;
        cnt      = 0;
        exp_busy = 0; exp_done = 0; exp_clr = 0;
        exp_a = '0; exp_b = '0; exp_av = '0; exp_bv = '0;
    endtask

    // Timeline after the accepting edge: 1 clear, 2..2N feed, ..3N drain, 3N+1 done.
    task automatic model_step();
        logic old_busy;
        bit   accept;
        int   t;
        if (!rst) begin
            model_reset();
            return;
        end
        old_busy = exp_busy;
        if (running) cnt++;
        exp_busy = 0; exp_done = 0; exp_clr = 0;
        exp_a = '0; exp_b = '0; exp_av = '0; exp_bv = '0;
        if (running) begin
            if (cnt == 1) begin
                exp_clr  = 1;
                exp_busy = 1;
            end else if (cnt <= 2*N) begin
                t = cnt - 2;
                exp_busy = 1;
                for (int i = 0; i < N; i++) begin
                    if (t - i >= 0 && t - i < N) begin
                        exp_a[i*DW +: DW] = ref_a[i][t-i];
                        exp_av[i]         = 1'b1;
                        exp_b[i*DW +: DW] = ref_b[t-i][i];
                        exp_bv[i]         = 1'b1;
                    end
                end
            end else if (cnt <= 3*N) begin
                exp_busy = 1;
            end else begin
                exp_done = 1;
            end
        end
        accept = start && (!running || cnt == 3*N+1);
        if (running && cnt == 3*N+1) running = 0;
        if (accept) begin
            running = 1;
            cnt     = 0;
        end
        if (wr_en && !old_busy) begin
            if (wr_sel) ref_b[wr_row][wr_col] = wr_data;
            else        ref_a[wr_row][wr_col] = wr_data;
        end
    endtask

    task automatic compare_all();
        check("busy",    busy,    exp_busy);
        check("done",    done,    exp_done);
        check("acc_clr", acc_clr, exp_clr);
        check("a_edge",  a_edge,  exp_a);
        check("b_edge",  b_edge,  exp_b);
        check("a_vld",   a_vld,   exp_av);
        check("b_vld",   b_vld,   exp_bv);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic write_elem(input logic sel, input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int d_cyc [3];
        int nd, gap0, busy_len;
        logic [N*DW-1:0] or_a, or_b;

        vecs[0] = '{1,  32'h0,        32'h0,        4'b0000, 4'b0000, 1, 0, 1};
        vecs[1] = '{2,  32'h00000000, 32'h00000080, 4'b0001, 4'b0001, 1, 0, 0};
        vecs[2] = '{3,  32'h00001001, 32'h00008190, 4'b0011, 4'b0011, 1, 0, 0};
        vecs[3] = '{5,  32'h30211203, 32'h8392A1B0, 4'b1111, 4'b1111, 1, 0, 0};
        vecs[4] = '{8,  32'h33000000, 32'hB3000000, 4'b1000, 4'b1000, 1, 0, 0};
        vecs[5] = '{9,  32'h0,        32'h0,        4'b0000, 4'b0000, 1, 0, 0};
        vecs[6] = '{12, 32'h0,        32'h0,        4'b0000, 4'b0000, 1, 0, 0};
        vecs[7] = '{13, 32'h0,        32'h0,        4'b0000, 4'b0000, 0, 1, 0};
        vecs[8] = '{14, 32'h0,        32'h0,        4'b0000, 4'b0000, 0, 0, 0};

        rst = 1'b0; wr_en = 0; wr_sel = 0; wr_row = 0; wr_col = 0; wr_data = 0; start = 0;
        model_reset();
        #2;
        compare_all();
        repeat (3) tick();
        rst = 1'b1;

        // Idle with no stimulus.
        repeat (10) tick();

        // Known tile, then table-driven FEED checks.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_elem(1'b0, r, c, 16*r + c);
                write_elem(1'b1, r, c, 16*r + c + 128);
            end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            for (int v = 0; v < 9; v++) begin
                if (vecs[v].k == k) begin
                    check("vec_a_edge", a_edge,  vecs[v].a);
                    check("vec_b_edge", b_edge,  vecs[v].b);
                    check("vec_a_vld",  a_vld,   vecs[v].av);
                    check("vec_b_vld",  b_vld,   vecs[v].bv);
                    check("vec_busy",   busy,    vecs[v].bsy);
                    check("vec_done",   done,    vecs[v].dn);
                    check("vec_acc_clr", acc_clr, vecs[v].clr);
                end
            end
        end

        // Write and start during FEED are both dropped.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 0; wr_col = 0; wr_data = 8'hFF; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        repeat (12) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_len = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (busy) busy_len++;
            if (c == 2) check("ignored_write_a00", a_edge[7:0], 8'h00);
        end
        check("busy_length", busy_len, 12);

        // Write and start in the same cycle: write lands in the stream.
        wr_en = 1'b1; wr_sel = 1'b1; wr_row = 3; wr_col = 3; wr_data = 8'h5A; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 8) check("same_cycle_b33", b_edge[31:24], 8'h5A);
        end

        // start held high: back-to-back runs through DONE.
        d_cyc = '{-100, -200, -300};
        nd = 0; gap0 = 0;
        start = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (nd == 1 && !busy) gap0++;
            if (done && nd < 3) begin
                d_cyc[nd] = c;
                nd++;
            end
        end
        start = 1'b0;
        check("done_period_1", d_cyc[1] - d_cyc[0], 13);
        check("done_period_2", d_cyc[2] - d_cyc[1], 13);
        check("idle_gap", gap0, 1);
        repeat (16) tick();

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_sel  = 1'($urandom_range(1));
            wr_row  = 2'($urandom_range(3));
            wr_col  = 2'($urandom_range(3));
            wr_data = 8'($urandom_range(255));
            start   = ($urandom_range(15) == 0);
            tick();
        end
        wr_en = 1'b0; start = 1'b0;
        repeat (16) tick();

        // Reset mid-FEED at t=2.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_clr",    acc_clr, 1'b0);
        check("rst_a_edge", a_edge, '0);
        check("rst_b_edge", b_edge, '0);
        check("rst_a_vld",  a_vld,  '0);
        check("rst_b_vld",  b_vld,  '0);
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        or_a = '0; or_b = '0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            or_a |= a_edge;
            or_b |= b_edge;
        end
        check("post_rst_a_zero", or_a, '0);
        check("post_rst_b_zero", or_b, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the N×N systolic array of PE_module instances.
- Holds one N×N tile of operand A and one of operand B in local buffers, loaded by a simple write port.
- On start it pulses an accumulator clear, then streams A rows into the array's left edge and B columns into its top edge with diagonal skew.
- Waits a drain period so the products reach the far PE, then signals done.

Parameters:
- N, 4: array dimension; also the tile size and the inner dimension K.
- DW, 8: operand width; matches the PE a/b width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- wr_en  input  1  buffer write strobe
- wr_sel  input  1  0 = write A buffer, 1 = write B buffer
- wr_row  input  $clog2(N)  element row index
- wr_col  input  $clog2(N)  element column index
- wr_data  input  DW  element value, unsigned
- start  input  1  begin one tile computation
- busy  output  1  sequence in progress
- done  output  1  one-cycle completion pulse
- acc_clr  output  1  one-cycle clear to PE accumulators
- a_edge  output  N*DW  lane i at bits [i*DW +: DW] feeds PE row i, column 0
- b_edge  output  N*DW  lane j at bits [j*DW +: DW] feeds PE row 0, column j
- a_vld  output  N  lane i of a_edge carries a real element
- b_vld  output  N  lane j of b_edge carries a real element

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-low.
- Reset values (rst=0):
  - Every output is 0.
  - The state machine is in IDLE and the step counter is 0.
  - All A and B buffer entries are 0.
- Outputs are registered, with no combinational path from any input to any output.
- Buffer writes:
  - When wr_en=1 and busy=0, the addressed entry is updated at the clock edge: A[wr_row][wr_col] if wr_sel=0, otherwise B[wr_row][wr_col].
  - Writes while busy=1 are ignored and buffers are unchanged.
  - Index values of N or more are ignored; this only applies when N is not a power of 2.
  - A write and a start in the same cycle: the write is committed, and the streamed data includes it.
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE: all outputs 0. A start=1 sampled here goes to CLEAR.
  - CLEAR: 1 cycle, with acc_clr=1, busy=1 and edges 0. Next state is FEED with step t=0.
  - FEED: 2N-1 cycles, t = 0 .. 2N-2, with busy=1.
    - Lane i of a_edge = A[i][t-i] when 0 ≤ t-i < N, else 0; a_vld[i] is set under the same condition.
    - Lane j of b_edge = B[t-j][j] when 0 ≤ t-j < N, else 0; b_vld[j] is set likewise.
    - After t=2N-2, next state is DRAIN.
  - DRAIN: N cycles with busy=1 and edges and valids 0. Covers the PE register hops to PE(N-1,N-1). Next state is DONE.
  - DONE: 1 cycle with done=1, busy=0 and edges 0.
    - start=1 here goes straight to CLEAR (back-to-back tiles).
    - Otherwise next state is IDLE.
- Timing and latency:
  - busy stays high for exactly 3N cycles (CLEAR + FEED + DRAIN).
  - done asserts 3N+1 cycles after the edge that samples start.
- start while busy=1 is ignored, with no queuing.
- Buffers hold their contents across runs; re-running without writes streams identical data.
- Reset asserted mid-operation: outputs clear immediately, buffers clear, and the block enters IDLE. No done is generated.
- Width rules: elements are passed through unmodified, with no arithmetic on data. The step counter must hold 0 .. 2N-2.

Test Plan:
1. N=4, reset then idle, no stimulus -> all outputs 0; no busy or done ever seen.
2. Load A[i][k]=16i+k and B[k][j]=16k+j+128 (j = column index), then start -> the following response:
   - acc_clr high 1 cycle.
   - FEED t=0: a lane0=0x00, b lane0=0x80, vld=4'b0001.
   - FEED t=3: a lanes = {0x30,0x21,0x12,0x03} (lane3..lane0); a_vld=4'b1111.
   - FEED t=6: a lane3=0x33, b lane3=0xB3, vld=4'b1000.
   - done exactly 13 cycles after the start edge.
3. Issue wr_en to A[0][0]=0xFF and start=1 during FEED -> write is ignored and start is ignored. The following run streams the original A[0][0]=0x00, and busy stays high for exactly 12 cycles.
4. Drop rst to 0 at FEED t=2 -> a_edge, b_edge, valids and busy are 0 the same cycle with no clock needed. After release the block sits in IDLE, and a new start streams all zeros.
5. Hold start=1 continuously -> the DONE cycle re-enters CLEAR. done pulses every 13 cycles, with exactly one busy=0 cycle between runs.
6. Apply wr_en and start in the same cycle writing B[3][3]=0x5A -> at FEED t=6, b lane3=0x5A.
